booth_seq_mul_dyn: RTL

- Parametrised, iterative radix-2 Booth signed multiplier with a dynamically selectable precision mode.
- One WIDTH x WIDTH product, or two independent (WIDTH/2) x (WIDTH/2) lane products computed in parallel in the same datapath.
- Sits in the DNN arithmetic-unit array as the sequential, area-lean counterpart of the combinational composable multipliers.
- valid/ready handshakes on both sides.

---
 rtl/booth_seq_mul_dyn.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/booth_seq_mul_dyn.sv
// Iterative radix-2 Booth signed multiplier with a run-time precision mode:
// one WIDTH x WIDTH product, or two independent WIDTH/2 x WIDTH/2 lane
// products sharing the same accumulator registers. valid/ready on both sides.
module booth_seq_mul_dyn #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One full-width Booth step. The returned vector is the shifted
    // {high (WIDTH+1), low (WIDTH), q_-1} triple.
    function automatic logic [2*WIDTH+1:0] booth_step_full(
        input logic [WIDTH:0]   hi,
        input logic [WIDTH-1:0] lo,
        input logic             qm1,
        input logic [WIDTH-1:0] mc
    );
        logic [WIDTH:0] mx;
        logic [WIDTH:0] sum;
        mx = {mc[WIDTH-1], mc};
        case ({lo[0], qm1})
            2'b01:   sum = hi + mx;
            2'b10:   sum = hi - mx;
            default: sum = hi;
        endcase
        return {sum[WIDTH], sum, lo};
    endfunction

    // One lane-width Booth step; same packing as the full step with HALF bits.
    function automatic logic [WIDTH+1:0] booth_step_lane(
        input logic [HALF:0]   hi,
        input logic [HALF-1:0] lo,
        input logic            qm1,
        input logic [HALF-1:0] mc
    );
        logic [HALF:0] mx;
        logic [HALF:0] sum;
        mx = {mc[HALF-1], mc};
        case ({lo[0], qm1})
            2'b01:   sum = hi + mx;
            2'b10:   sum = hi - mx;
            default: sum = hi;
        endcase
        return {sum[HALF], sum, lo};
    endfunction

    // Accumulator high half is WIDTH+2 bits so that in split mode each lane
    // gets its own HALF+1 bit guard-extended high half; full mode uses [WIDTH:0].
    state_t               state_q, state_d;
    logic [WIDTH+1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [1:0]           qm1_q, qm1_d;
    logic [WIDTH-1:0]     mc_q, mc_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [2*WIDTH+1:0]   full_s;
    logic [WIDTH+1:0]     lane0_s;
    logic [WIDTH+1:0]     lane1_s;

    // Next-state, datapath step and result capture.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qm1_d     = qm1_q;
        mc_d      = mc_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        full_s  = booth_step_full(hi_q[WIDTH:0], lo_q, qm1_q[0], mc_q);
        lane0_s = booth_step_lane(hi_q[HALF:0], lo_q[HALF-1:0], qm1_q[0], mc_q[HALF-1:0]);
        lane1_s = booth_step_lane(hi_q[WIDTH+1:HALF+1], lo_q[WIDTH-1:HALF], qm1_q[1],
                                  mc_q[WIDTH-1:HALF]);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mc_d    = m;
                    mode_d  = mode;
                    hi_d    = {(WIDTH+2){1'b0}};
                    lo_d    = q;
                    qm1_d   = 2'b00;
                    cnt_d   = mode ? CNT_W'(HALF) : CNT_W'(WIDTH);
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mode_q) begin
                    hi_d  = {lane1_s[WIDTH+1:HALF+1], lane0_s[WIDTH+1:HALF+1]};
                    lo_d  = {lane1_s[HALF:1], lane0_s[HALF:1]};
                    qm1_d = {lane1_s[0], lane0_s[0]};
                end else begin
                    hi_d  = {1'b0, full_s[2*WIDTH+1:WIDTH+1]};
                    lo_d  = full_s[WIDTH:1];
                    qm1_d = {1'b0, full_s[0]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last step: capture the finished product straight from
                    // the stepped accumulator so it is stable for all of DONE.
                    if (mode_q) begin
                        product_d = {lane1_s[WIDTH:1], lane0_s[WIDTH:1]};
                    end else begin
                        product_d = full_s[2*WIDTH:1];
                    end
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, accumulator and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= {(WIDTH+2){1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            qm1_q     <= 2'b00;
            mc_q      <= {WIDTH{1'b0}};
            mode_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            qm1_q     <= qm1_d;
            mc_q      <= mc_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule
